lm32_ram: RTL and testbench

LM32_RAM -- requirements
Module: lm32_ram

---
 rtl/lm32_ram_pkg.sv | 8 +
 rtl/lm32_ram_if.sv | 28 ++
 rtl/lm32_ram.sv | 74 +++++++
 tb/tb_lm32_ram.sv | 108 ++++++++++
 4 files changed

// File: rtl/lm32_ram_pkg.sv
// Shared lm32 constants: boolean levels and the reset-sensitivity convention.
package lm32_ram_pkg;

    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;
    localparam logic RST_ACTIVE = TRUE;

endpackage

// File: rtl/lm32_ram_if.sv
// Read/write port bundle for lm32_ram; the master drives addresses, strobes and
// write data, and the slave (the RAM) returns read data.
interface lm32_ram_if #(
    parameter int data_width    = 1,
    parameter int address_width = 1
);

    logic [address_width-1:0] read_address;
    logic                     enable_read;
    logic [address_width-1:0] write_address;
    logic                     enable_write;
    logic                     write_enable;
    logic [data_width-1:0]    write_data;
    logic [data_width-1:0]    read_data;

    modport master (
        output read_address, enable_read, write_address,
               enable_write, write_enable, write_data,
        input  read_data
    );

    modport slave (
        input  read_address, enable_read, write_address,
               enable_write, write_enable, write_data,
        output read_data
    );

endinterface

// File: rtl/lm32_ram.sv
// Simple dual-port RAM with registered read address and write-through reads.
// Define LM32_RAM_INIT_ZERO_EN to start every word at zero.
module lm32_ram
    import lm32_ram_pkg::*;
#(
    parameter int data_width    = 1,
    parameter int address_width = 1
) (
    input  logic                     read_clk,
    input  logic                     write_clk,
    input  logic                     reset,
    input  logic [address_width-1:0] read_address,
    input  logic                     enable_read,
    input  logic [address_width-1:0] write_address,
    input  logic                     enable_write,
    input  logic                     write_enable,
    input  logic [data_width-1:0]    write_data,
    output logic [data_width-1:0]    read_data
);

    localparam int DEPTH = 1 << address_width;

    logic [data_width-1:0]    mem_q [0:DEPTH-1];
    logic [address_width-1:0] ra_q;
    logic [address_width-1:0] ra_d;
    logic                     wr_s;

`ifdef LM32_RAM_INIT_ZERO_EN
    // Known power-up contents for builds that cannot tolerate X reads.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = '0;
        end
    end
`endif

    // Write strobe requires both the port enable and the write strobe.
    always_comb begin
        wr_s = FALSE;
        if ((enable_write == TRUE) && (write_enable == TRUE)) begin
            wr_s = TRUE;
        end else begin
            wr_s = FALSE;
        end
    end

    // Next read address: reset wins over a capture request.
    always_comb begin
        ra_d = ra_q;
        if (reset == RST_ACTIVE) begin
            ra_d = '0;
        end else if (enable_read == TRUE) begin
            ra_d = read_address;
        end else begin
            ra_d = ra_q;
        end
    end

    // Read-address register; memory contents are untouched by reset.
    always_ff @(posedge read_clk) begin
        ra_q <= ra_d;
    end

    // Write port; runs even while reset is asserted.
    always_ff @(posedge write_clk) begin
        if (wr_s == TRUE) begin
            mem_q[write_address] <= write_data;
        end
    end

    // Combinational read off the registered address gives write-through.
    assign read_data = mem_q[ra_q];

endmodule

// File: tb/tb_lm32_ram.sv
// Directed scoreboard bench for lm32_ram (31-bit words, 1024 entries).
module tb_lm32_ram;

    localparam int DW = 31;
    localparam int AW = 10;

    typedef struct {
        string         tag;
        logic [DW-1:0] data;
    } exp_t;

    logic   clk;
    logic   reset;
    int     checks;
    int     failures;
    exp_t   sb_q [$];

    lm32_ram_if #(.data_width(DW), .address_width(AW)) bus ();

    lm32_ram #(.data_width(DW), .address_width(AW)) dut (
        .read_clk      (clk),
        .write_clk     (clk),
        .reset         (reset),
        .read_address  (bus.read_address),
        .enable_read   (bus.enable_read),
        .write_address (bus.write_address),
        .enable_write  (bus.enable_write),
        .write_enable  (bus.write_enable),
        .write_data    (bus.write_data),
        .read_data     (bus.read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input string         tag,
        input logic          rst,
        input logic          er,
        input logic [AW-1:0] ra,
        input logic          ew,
        input logic          we,
        input logic [AW-1:0] wa,
        input logic [DW-1:0] wd,
        input logic [DW-1:0] exp_data
    );
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset             = rst;
        bus.enable_read   = er;
        bus.read_address  = ra;
        bus.enable_write  = ew;
        bus.write_enable  = we;
        bus.write_address = wa;
        bus.write_data    = wd;
        e.tag  = tag;
        e.data = exp_data;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (bus.read_data === got.data) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", got.tag, bus.read_data, got.data);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        bus.enable_read   = 1'b0;
        bus.read_address  = 10'h000;
        bus.enable_write  = 1'b0;
        bus.write_enable  = 1'b0;
        bus.write_address = 10'h000;
        bus.write_data    = 31'h0;

`ifdef LM32_RAM_INIT_ZERO_EN
        step("init0",    1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 31'h0, 31'h0);
        step("init512",  1'b0, 1'b1, 10'h200, 1'b0, 1'b0, 10'h000, 31'h0, 31'h0);
        step("init1023", 1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 31'h0, 31'h0);
`endif
        // Write during reset lands; read register cleared to 0.
        step("reset_wr0",     1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 31'h0ABCDE1, 31'h0ABCDE1);
        step("wr5_hold_ra",   1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h005, 31'h12345677, 31'h0ABCDE1);
        step("rd5",           1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 10'h000, 31'h0, 31'h12345677);
        step("we_low_nowr",   1'b0, 1'b0, 10'h005, 1'b1, 1'b0, 10'h005, 31'h0, 31'h12345677);
        step("ew_low_nowr",   1'b0, 1'b0, 10'h005, 1'b0, 1'b1, 10'h005, 31'h0, 31'h12345677);
        step("write_through", 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h005, 31'h00000001, 31'h00000001);
        step("wr_other_word", 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h006, 31'h05555555, 31'h00000001);
        step("same_edge_3ff", 1'b0, 1'b1, 10'h3FF, 1'b1, 1'b1, 10'h3FF, 31'h7FFFFFFF, 31'h7FFFFFFF);
        step("hold_3ff",      1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 31'h0, 31'h7FFFFFFF);
        step("rd5_again",     1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 10'h000, 31'h0, 31'h00000001);
        // Reset must override a simultaneous capture request.
        step("reset_prio",    1'b1, 1'b1, 10'h006, 1'b0, 1'b0, 10'h000, 31'h0, 31'h0ABCDE1);
        step("rd5_post_rst",  1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 10'h000, 31'h0, 31'h00000001);
        step("rd6",           1'b0, 1'b1, 10'h006, 1'b0, 1'b0, 10'h000, 31'h0, 31'h05555555);
        step("er_low_holds",  1'b0, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 31'h0, 31'h05555555);
        step("rd_3ff",        1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 31'h0, 31'h7FFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
